// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame out, ACK check.
// Shares the open-drain bus with the receive path; rx_block gates it while busy.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 12000,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_valid,
  input  logic [7:0] tx_data,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_error,
  output logic [1:0] tx_err_code,
  output logic       rx_block,
  inout  wire        PS2_CLK,
  inout  wire        PS2_DATA
);

  localparam int IW = ($clog2(INHIBIT_CYCLES) < 1) ? 1 : $clog2(INHIBIT_CYCLES);
  localparam int TW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);
  localparam logic [IW-1:0] INH_LAST = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_SEND,
    S_ACK,
    S_WAIT
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [1:0]      r_clk_sync;
  logic [1:0]      r_dat_sync;
  logic            r_clk_prev;
  logic [8:0]      r_shift;
  logic [IW-1:0]   r_inh_cnt;
  logic [TW-1:0]   r_tmo;
  logic [3:0]      r_fall_cnt;
  logic            r_data_low;
  logic            r_done;
  logic            r_error;
  logic [1:0]      r_err_code;

  logic            w_clk_s;
  logic            w_dat_s;
  logic            w_fall;
  logic            w_inh_last;
  logic            w_active;
  logic            w_tmo;
  logic            w_bus_idle;
  logic            w_clk_low;
  logic            w_data_low;

  assign w_clk_s    = r_clk_sync[1];
  assign w_dat_s    = r_dat_sync[1];
  assign w_fall     = r_clk_prev & ~w_clk_s;
  assign w_inh_last = (r_inh_cnt == INH_LAST);
  assign w_bus_idle = w_clk_s & w_dat_s;
  assign w_active   = (r_state == S_SEND) ||
                      (r_state == S_ACK)  ||
                      (r_state == S_WAIT);
  assign w_tmo      = w_active && (r_tmo == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
      r_clk_prev <= 1'b1;
    end else begin
      r_clk_sync <= {r_clk_sync[0], PS2_CLK};
      r_dat_sync <= {r_dat_sync[0], PS2_DATA};
      r_clk_prev <= w_clk_s;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // Timeout is checked first so it wins over a coincident fall 11.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (tx_valid) w_next = S_INHIBIT;
      S_INHIBIT: if (w_inh_last) w_next = S_SEND;
      S_SEND: begin
        if (w_tmo) w_next = S_IDLE;
        else if (w_fall && r_fall_cnt == 4'd9) w_next = S_ACK;
      end
      S_ACK: begin
        if (w_tmo) w_next = S_IDLE;
        else if (w_fall) w_next = w_dat_s ? S_IDLE : S_WAIT;
      end
      S_WAIT: begin
        if (w_tmo) w_next = S_IDLE;
        else if (w_bus_idle) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift    <= '0;
      r_inh_cnt  <= '0;
      r_tmo      <= '0;
      r_fall_cnt <= '0;
      r_data_low <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_code <= 2'b00;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (tx_valid) begin
            r_shift    <= {~^tx_data, tx_data};
            r_err_code <= 2'b00;
            r_inh_cnt  <= '0;
          end
        end
        S_INHIBIT: begin
          r_inh_cnt <= r_inh_cnt + 1'b1;
          if (w_inh_last) begin
            r_fall_cnt <= '0;
            r_tmo      <= '0;
            r_data_low <= 1'b1;
          end
        end
        S_SEND, S_ACK, S_WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          if (w_tmo) begin
            r_error    <= 1'b1;
            r_err_code <= 2'b10;
          end else if (r_state == S_SEND) begin
            if (w_fall) begin
              r_fall_cnt <= r_fall_cnt + 1'b1;
              if (r_fall_cnt == 4'd9) begin
                r_data_low <= 1'b0;
              end else begin
                r_data_low <= ~r_shift[0];
                r_shift    <= {1'b0, r_shift[8:1]};
              end
            end
          end else if (r_state == S_ACK) begin
            if (w_fall) begin
              r_fall_cnt <= r_fall_cnt + 1'b1;
              if (w_dat_s) begin
                r_error    <= 1'b1;
                r_err_code <= 2'b01;
              end
            end
          end else begin
            if (w_bus_idle) r_done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    tx_ready   = (r_state == S_IDLE);
    rx_block   = (r_state != S_IDLE);
    w_clk_low  = (r_state == S_INHIBIT);
    w_data_low = ((r_state == S_INHIBIT) && w_inh_last) ||
                 ((r_state == S_SEND) && r_data_low);
  end

  assign tx_done     = r_done;
  assign tx_error    = r_error;
  assign tx_err_code = r_err_code;

  assign PS2_CLK  = w_clk_low  ? 1'b0 : 1'bz;
  assign PS2_DATA = w_data_low ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: pulled-up bus plus a clocking keyboard model.
// Directed frames from a vector table, then hand-written corner sequences.
module tb_ps2_host_tx;

  localparam int HALF = 40;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_ready;
  logic       tx_done;
  logic       tx_error;
  logic [1:0] tx_err_code;
  logic       rx_block;
  wire        ps2_clk;
  wire        ps2_data;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  pullup (ps2_clk);
  pullup (ps2_data);
  assign ps2_clk  = dev_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = dev_data_low ? 1'b0 : 1'bz;

  ps2_host_tx #(
    .INHIBIT_CYCLES(20),
    .TIMEOUT_CYCLES(5000)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_valid   (tx_valid),
    .tx_data    (tx_data),
    .tx_ready   (tx_ready),
    .tx_done    (tx_done),
    .tx_error   (tx_error),
    .tx_err_code(tx_err_code),
    .rx_block   (rx_block),
    .PS2_CLK    (ps2_clk),
    .PS2_DATA   (ps2_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always @(negedge clk) begin
    if (tx_done) done_cnt++;
    if (tx_error) err_cnt++;
    if (tx_done && tx_error) both_cnt++;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       ack;
    logic [1:0] code;
  } vec_t;

  vec_t vecs[5];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  // Keyboard model: measures inhibit, then clocks 11 bits; stop_at>0 aborts
  // with the clock held low after that fall.
  task automatic dev_rx(input logic ack, input int stop_at,
                        output logic [10:0] fr, output int inh);
    int n;
    fr  = '0;
    inh = 0;
    n   = 0;
    while (ps2_clk !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    while (ps2_clk === 1'b0 && inh < 1000) begin
      @(negedge clk);
      inh++;
    end
    fr[0] = ps2_data;
    for (int k = 1; k <= 11; k++) begin
      repeat (HALF / 2) @(negedge clk);
      if (k == 11 && ack) dev_data_low = 1'b1;
      repeat (HALF / 2) @(negedge clk);
      dev_clk_low = 1'b1;
      if (k == stop_at) begin
        repeat (20) @(negedge clk);
        return;
      end
      repeat (HALF) @(negedge clk);
      dev_clk_low = 1'b0;
      @(negedge clk);
      if (k <= 10) fr[k] = ps2_data;
    end
    repeat (HALF) @(negedge clk);
    dev_data_low = 1'b0;
  endtask

  logic [10:0] fr;
  logic [10:0] fr2;
  int          inh;
  int          inh2;
  int          d0;
  int          e0;
  int          cnt;
  int          lows;

  initial begin
    vecs[0] = '{data: 8'hED, par: 1'b1, ack: 1'b1, code: 2'b00};
    vecs[1] = '{data: 8'h3C, par: 1'b1, ack: 1'b0, code: 2'b01};
    vecs[2] = '{data: 8'h00, par: 1'b1, ack: 1'b1, code: 2'b00};
    vecs[3] = '{data: 8'hFF, par: 1'b1, ack: 1'b1, code: 2'b00};
    vecs[4] = '{data: 8'h80, par: 1'b0, ack: 1'b1, code: 2'b00};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(tx_ready), 32'd1);
    chk("rst_done", 32'(tx_done), 32'd0);
    chk("rst_error", 32'(tx_error), 32'd0);
    chk("rst_code", 32'(tx_err_code), 32'd0);
    chk("rst_rxblock", 32'(rx_block), 32'd0);
    chk("rst_clk_line", 32'(ps2_clk), 32'd1);
    chk("rst_data_line", 32'(ps2_data), 32'd1);

    foreach (vecs[i]) begin
      d0 = done_cnt;
      e0 = err_cnt;
      send(vecs[i].data);
      chk("vec_rxblock", 32'(rx_block), 32'd1);
      dev_rx(vecs[i].ack, 0, fr, inh);
      repeat (20) @(negedge clk);
      chk("vec_inhibit", 32'(inh), 32'd20);
      chk("vec_frame", 32'(fr),
          32'({1'b1, vecs[i].par, vecs[i].data, 1'b0}));
      chk("vec_done", 32'(done_cnt - d0), 32'(vecs[i].ack));
      chk("vec_error", 32'(err_cnt - e0), 32'(!vecs[i].ack));
      chk("vec_code", 32'(tx_err_code), 32'(vecs[i].code));
      chk("vec_ready", 32'(tx_ready), 32'd1);
      chk("vec_rxblock_end", 32'(rx_block), 32'd0);
      chk("vec_clk_line", 32'(ps2_clk), 32'd1);
      chk("vec_data_line", 32'(ps2_data), 32'd1);
    end

    // 0x07 with a stray 0xFF request in flight
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h07);
    fork
      dev_rx(1'b1, 0, fr, inh);
      begin
        repeat (300) @(negedge clk);
        tx_data  = 8'hFF;
        tx_valid = 1'b1;
        repeat (2) @(negedge clk);
        tx_valid = 1'b0;
      end
    join
    repeat (20) @(negedge clk);
    chk("ign_frame", 32'(fr), 32'({1'b1, 1'b0, 8'h07, 1'b0}));
    chk("ign_done", 32'(done_cnt - d0), 32'd1);
    chk("ign_error", 32'(err_cnt - e0), 32'd0);
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ps2_clk !== 1'b1) lows++;
    end
    chk("ign_no_second", 32'(lows), 32'd0);

    // device never clocks
    e0 = err_cnt;
    send(8'hAB);
    cnt = 0;
    while (ps2_clk === 1'b0 && cnt < 1000) begin
      @(negedge clk);
      cnt++;
    end
    cnt = 0;
    while (!tx_error && cnt < 6000) begin
      @(negedge clk);
      cnt++;
    end
    chk("tmo_cycles", 32'(cnt), 32'd5000);
    chk("tmo_code", 32'(tx_err_code), 32'd2);
    chk("tmo_ready", 32'(tx_ready), 32'd1);
    chk("tmo_clk_line", 32'(ps2_clk), 32'd1);
    chk("tmo_data_line", 32'(ps2_data), 32'd1);
    repeat (5) @(negedge clk);
    chk("tmo_error_cnt", 32'(err_cnt - e0), 32'd1);

    // reset after fall 4 of 0x55 (bit 3 is 0, so data is low)
    d0 = done_cnt;
    e0 = err_cnt;
    send(8'h55);
    dev_rx(1'b1, 4, fr, inh);
    chk("rst_mid_data_low", 32'(ps2_data), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_data_rel", 32'(ps2_data), 32'd1);
    chk("rst_mid_ready", 32'(tx_ready), 32'd1);
    chk("rst_mid_rxblock", 32'(rx_block), 32'd0);
    rst = 1'b0;
    dev_clk_low = 1'b0;
    repeat (50) @(negedge clk);
    chk("rst_mid_clk_line", 32'(ps2_clk), 32'd1);
    chk("rst_mid_pulses", 32'(done_cnt - d0 + err_cnt - e0), 32'd0);
    send(8'hF4);
    dev_rx(1'b1, 0, fr, inh);
    repeat (20) @(negedge clk);
    chk("post_rst_frame", 32'(fr), 32'({1'b1, 1'b0, 8'hF4, 1'b0}));
    chk("post_rst_done", 32'(done_cnt - d0), 32'd1);

    // back-to-back with tx_valid held
    d0 = done_cnt;
    tx_data  = 8'hED;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_data = 8'h02;
    dev_rx(1'b1, 0, fr, inh);
    cnt = 0;
    while (!tx_done && cnt < 200) begin
      @(negedge clk);
      cnt++;
    end
    chk("b2b_ready_at_done", 32'(tx_ready), 32'd1);
    @(negedge clk);
    chk("b2b_second_accept", 32'(tx_ready), 32'd0);
    tx_valid = 1'b0;
    dev_rx(1'b1, 0, fr2, inh2);
    repeat (20) @(negedge clk);
    chk("b2b_frame1", 32'(fr), 32'({1'b1, 1'b1, 8'hED, 1'b0}));
    chk("b2b_frame2", 32'(fr2), 32'({1'b1, 1'b0, 8'h02, 1'b0}));
    chk("b2b_inhibit2", 32'(inh2), 32'd20);
    chk("b2b_done", 32'(done_cnt - d0), 32'd2);

    chk("never_both", 32'(both_cnt), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
